// File: rtl/icache_sa.sv
// ----------------------------------------------------------------------------
// icache_sa : parametrised set-associative instruction cache (1 or 2 ways).
//
// Serves word reads with a one-cycle registered response on hit. A miss fetches
// the whole line over a valid/ready memory handshake, fills the victim way and
// then returns the requested word (3 cycles plus memory handshake delay).
//
// Optional build macro: ICACHE_STATS_EN adds saturating hit/miss counters.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   flush              invalidate all lines (honoured only in IDLE)
//   req_valid/addr     fetch request, word-aligned byte address
//   req_ready          cache can accept a request (low while flush is high)
//   resp_valid         one-cycle response pulse
//   resp_instr         returned word (holds while resp_valid is low)
//   hit                qualifies resp_valid: 1 = hit, 0 = filled after miss
//   mem_req_valid/addr line fetch request, line-aligned address
//   mem_req_ready      memory accepts the fetch
//   mem_resp_valid     line data valid
//   mem_resp_line      fetched line, word 0 in the LSBs
//   hit_count          (ICACHE_STATS_EN) saturating hit response count
//   miss_count         (ICACHE_STATS_EN) saturating miss count
// ----------------------------------------------------------------------------
module icache_sa #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned SETS       = 8,
    parameter int unsigned WAYS       = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         req_valid,
    input  logic [ADDR_W-1:0]            req_addr,
    output logic                         req_ready,
    output logic                         resp_valid,
    output logic [WORD_W-1:0]            resp_instr,
    output logic                         hit,
    output logic                         mem_req_valid,
    output logic [ADDR_W-1:0]            mem_req_addr,
    input  logic                         mem_req_ready,
    input  logic                         mem_resp_valid,
    input  logic [LINE_WORDS*WORD_W-1:0] mem_resp_line
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
`endif
);

    localparam int unsigned BYTE_W     = 2;
    localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
    localparam int unsigned IDX_BITS   = $clog2(SETS);
    localparam int unsigned IDX_W      = (IDX_BITS > 0) ? IDX_BITS : 1;
    localparam int unsigned TAG_W      = ADDR_W - BYTE_W - OFF_W - IDX_BITS;
    localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        RESP      = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Storage: valid and LRU bits are reset; tags and data are plain arrays.
    logic [WAYS-1:0][SETS-1:0] valid_q, valid_d;
    logic [SETS-1:0]           lru_q, lru_d;
    logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
    logic [LINE_W-1:0]         data_q [WAYS][SETS];

    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic              resp_valid_q, resp_valid_d;
    logic              hit_q, hit_d;
    logic [WORD_W-1:0] resp_instr_q, resp_instr_d;
    logic              mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0] mem_req_addr_q, mem_req_addr_d;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
`endif

    // Address fields of the incoming request and of the captured miss.
    logic [IDX_W-1:0] req_idx, miss_idx;
    logic [OFF_W-1:0] req_off, miss_off;
    logic [TAG_W-1:0] req_tag, miss_tag;

    assign req_idx  = IDX_W'(req_addr >> (BYTE_W + OFF_W)) & IDX_W'(SETS - 1);
    assign req_off  = OFF_W'(req_addr >> BYTE_W);
    assign req_tag  = TAG_W'(req_addr >> (BYTE_W + OFF_W + IDX_BITS));
    assign miss_idx = IDX_W'(miss_addr_q >> (BYTE_W + OFF_W)) & IDX_W'(SETS - 1);
    assign miss_off = OFF_W'(miss_addr_q >> BYTE_W);
    assign miss_tag = TAG_W'(miss_addr_q >> (BYTE_W + OFF_W + IDX_BITS));

    // Tag compare against every way of the addressed set.
    logic [WAYS-1:0]   hit_vec;
    logic              hit_any;
    logic              hit_way;
    logic [LINE_W-1:0] hit_line;
    logic [WORD_W-1:0] hit_word;

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
        end
    end

    assign hit_any  = |hit_vec;
    assign hit_way  = (WAYS == 2) ? hit_vec[WAYS-1] : 1'b0;
    assign hit_line = data_q[hit_way][req_idx];
    assign hit_word = hit_line[req_off*WORD_W +: WORD_W];

    // Victim: first invalid way (lowest index first), otherwise the LRU way.
    logic              victim_way;
    logic [WORD_W-1:0] fill_word;
    logic              fill_en;

    always_comb begin
        victim_way = 1'b0;
        if (WAYS == 2) begin
            if (!valid_q[0][miss_idx]) begin
                victim_way = 1'b0;
            end else if (!valid_q[WAYS-1][miss_idx]) begin
                victim_way = 1'b1;
            end else begin
                victim_way = lru_q[miss_idx];
            end
        end
    end

    assign fill_word = mem_resp_line[miss_off*WORD_W +: WORD_W];

    // Requests are only taken in IDLE, and a flush blocks them that cycle.
    assign req_ready = (state_q == IDLE) && !flush;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!flush && req_valid && !hit_any) state_d = MISS_REQ;
            MISS_REQ:  if (mem_req_ready) state_d = MISS_WAIT;
            MISS_WAIT: if (mem_resp_valid) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output and storage-update logic.
    always_comb begin
        resp_valid_d    = 1'b0;
        hit_d           = 1'b0;
        resp_instr_d    = resp_instr_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        miss_addr_d     = miss_addr_q;
        valid_d         = valid_q;
        lru_d           = lru_q;
        fill_en         = 1'b0;
`ifdef ICACHE_STATS_EN
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
`endif
        case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                    lru_d   = '0;
`ifdef ICACHE_STATS_EN
                    hit_count_d  = '0;
                    miss_count_d = '0;
`endif
                end else if (req_valid) begin
                    if (hit_any) begin
                        resp_valid_d = 1'b1;
                        hit_d        = 1'b1;
                        resp_instr_d = hit_word;
                        if (WAYS == 2) lru_d[req_idx] = ~hit_way;
`ifdef ICACHE_STATS_EN
                        if (hit_count_q != '1) hit_count_d = hit_count_q + 32'd1;
`endif
                    end else begin
                        miss_addr_d     = req_addr;
                        mem_req_addr_d  = req_addr & ~ADDR_W'(LINE_BYTES - 1);
                        mem_req_valid_d = 1'b1;
`ifdef ICACHE_STATS_EN
                        if (miss_count_q != '1) miss_count_d = miss_count_q + 32'd1;
`endif
                    end
                end
            end
            MISS_REQ: begin
                if (mem_req_ready) mem_req_valid_d = 1'b0;
            end
            MISS_WAIT: begin
                if (mem_resp_valid) begin
                    fill_en                      = 1'b1;
                    valid_d[victim_way][miss_idx] = 1'b1;
                    if (WAYS == 2) lru_d[miss_idx] = ~victim_way;
                    resp_valid_d                 = 1'b1;
                    resp_instr_d                 = fill_word;
                end
            end
            default: ;
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q         <= '0;
            lru_q           <= '0;
            miss_addr_q     <= '0;
            resp_valid_q    <= 1'b0;
            hit_q           <= 1'b0;
            resp_instr_q    <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
`ifdef ICACHE_STATS_EN
            hit_count_q     <= '0;
            miss_count_q    <= '0;
`endif
        end else begin
            valid_q         <= valid_d;
            lru_q           <= lru_d;
            miss_addr_q     <= miss_addr_d;
            resp_valid_q    <= resp_valid_d;
            hit_q           <= hit_d;
            resp_instr_q    <= resp_instr_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
`ifdef ICACHE_STATS_EN
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
`endif
        end
    end

    // Tag and data arrays need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[victim_way][miss_idx]  <= miss_tag;
            data_q[victim_way][miss_idx] <= mem_resp_line;
        end
    end

    assign resp_valid    = resp_valid_q;
    assign hit           = hit_q;
    assign resp_instr    = resp_instr_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
`ifdef ICACHE_STATS_EN
    assign hit_count     = hit_count_q;
    assign miss_count    = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_sa.sv
// ----------------------------------------------------------------------------
// tb_icache_sa : scoreboard bench for icache_sa (default parameters).
// Driver issues requests and plays the memory; a reference model of the
// cache contents (line addresses plus last-use timestamps) predicts hit/miss
// and the word, which is queued; the monitor pops on every resp_valid.
// ----------------------------------------------------------------------------
module tb_icache_sa;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned SETS       = 8;
    localparam int unsigned WAYS       = 2;
    localparam int unsigned LINE_W     = LINE_WORDS * WORD_W;
    localparam int unsigned LINE_BYTES = LINE_WORDS * 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_instr;
    logic              hit;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [LINE_W-1:0] mem_resp_line;
`ifdef ICACHE_STATS_EN
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    icache_sa #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_WORDS(LINE_WORDS),
        .SETS(SETS), .WAYS(WAYS)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_instr(resp_instr), .hit(hit),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_line(mem_resp_line)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Instruction memory image: explicit words, otherwise a fixed hash.
    logic [31:0] mem_img [logic [31:0]];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [LINE_W-1:0] build_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int i = 0; i < LINE_WORDS; i++) l[i*WORD_W +: WORD_W] = mem_word(la + 32'(i * 4));
        return l;
    endfunction

    // Reference model: which line lives in each way, and when it was last used.
    bit          m_valid [SETS][WAYS];
    logic [31:0] m_line  [SETS][WAYS];
    longint      m_stamp [SETS][WAYS];
    longint      now_t = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic model_access(input logic [31:0] a, output bit h);
        int          s;
        int          victim;
        logic [31:0] la;
        la = a - (a % LINE_BYTES);
        s  = int'((a / LINE_BYTES) % SETS);
        h  = 1'b0;
        now_t++;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_line[s][w] == la) begin
                h = 1'b1;
                m_stamp[s][w] = now_t;
            end
        end
        if (!h) begin
            victim = -1;
            for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && victim < 0) victim = w;
            if (victim < 0) begin
                victim = 0;
                for (int w = 1; w < WAYS; w++) if (m_stamp[s][w] < m_stamp[s][victim]) victim = w;
            end
            m_valid[s][victim] = 1'b1;
            m_line[s][victim]  = la;
            m_stamp[s][victim] = now_t;
            exp_misses++;
        end else begin
            exp_hits++;
        end
    endtask

    // Scoreboard queue: {hit, word}.
    logic [32:0] exp_q [$];
    logic [32:0] mon_e;
    logic [31:0] last_instr;

    always @(negedge clk) begin
        if (rst) begin
            last_instr = '0;
        end else if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp", 64'({hit, resp_instr}), 64'(mon_e));
                last_instr = mon_e[31:0];
            end
        end else begin
            chk("instr_hold", 64'(resp_instr), 64'(last_instr));
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    endtask

    // One fetch; on a miss also plays the memory side with 'hold' stall cycles.
    task automatic access(input logic [31:0] a, input int hold);
        bit          h;
        logic [31:0] la;
        int          d;
        wait_ready();
        model_access(a, h);
        exp_q.push_back({h, mem_word(a)});
        la             = a - (a % LINE_BYTES);
        req_valid      = 1'b1;
        req_addr       = a;
        mem_resp_valid = 1'($urandom_range(0, 1));
        mem_resp_line  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        req_valid      = 1'b0;
        mem_resp_valid = 1'b0;
        if (h) begin
            chk("hit_latency", 64'(resp_valid), 64'd1);
            chk("hit_no_memreq", 64'(mem_req_valid), 64'd0);
        end else begin
            chk("memreq_valid", 64'(mem_req_valid), 64'd1);
            chk("memreq_addr", 64'(mem_req_addr), 64'(la));
            for (int i = 0; i < hold; i++) begin
                req_valid = 1'($urandom_range(0, 1));
                req_addr  = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
                flush     = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk("stall_memreq_valid", 64'(mem_req_valid), 64'd1);
                chk("stall_memreq_addr", 64'(mem_req_addr), 64'(la));
                chk("stall_req_ready", 64'(req_ready), 64'd0);
            end
            mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            chk("memreq_drop", 64'(mem_req_valid), 64'd0);
            d = int'($urandom_range(0, 3));
            repeat (d) begin
                @(posedge clk); #1;
            end
            mem_resp_valid = 1'b1;
            mem_resp_line  = build_line(la);
            @(posedge clk); #1;
            mem_resp_valid = 1'b0;
            mem_resp_line  = {$urandom, $urandom, $urandom, $urandom};
            req_valid      = 1'b0;
            flush          = 1'b0;
            chk("miss_latency", 64'(resp_valid), 64'd0 | 64'd1);
        end
    endtask

    task automatic flush_op();
        wait_ready();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_addr  = $urandom_range(0, 511) & 32'hFFFF_FFFC;
        #1;
        chk("flush_blocks_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        model_clear();
        chk("flush_no_resp", 64'(resp_valid), 64'd0);
`ifdef ICACHE_STATS_EN
        chk("flush_hit_count", 64'(hit_count), 64'd0);
        chk("flush_miss_count", 64'(miss_count), 64'd0);
`endif
    endtask

    // Miss aborted by reset while waiting for the line.
    task automatic reset_abort();
        wait_ready();
        req_valid = 1'b1;
        req_addr  = 32'h11C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_memreq_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_memreq_drop", 64'(mem_req_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        mem_resp_valid = 1'b1;
        mem_resp_line  = build_line(32'h110);
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("abort_no_resp", 64'(resp_valid), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] ra;
        rst            = 1'b1;
        flush          = 1'b0;
        req_valid      = 1'b0;
        req_addr       = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_line  = '0;
        mem_img[32'h50] = 32'h0000_000A;
        mem_img[32'h54] = 32'h0000_000B;
        mem_img[32'h58] = 32'h0000_000C;
        mem_img[32'h5C] = 32'h0000_000D;
        model_clear();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_hit", 64'(hit), 64'd0);
        chk("rst_resp_instr", 64'(resp_instr), 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed sequence: fill, hit, LRU eviction, memory stall.
        access(32'h5C, 0);
        access(32'h58, 0);
        access(32'hDC, 0);
        access(32'h5C, 0);
        access(32'h15C, 5);
        access(32'h5C, 0);
        access(32'hDC, 0);

        reset_abort();
        access(32'h11C, 0);
        access(32'h5C, 1);

        // Flush after fills: everything misses again.
        access(32'h2C, 0);
        access(32'h1A8, 2);
        access(32'h5C, 0);
        flush_op();
        access(32'h5C, 0);
        access(32'h2C, 0);
        access(32'h1A8, 0);

        // Randomised traffic over a small footprint to mix hits and misses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                flush_op();
            end else begin
                ra = $urandom_range(0, 511) & 32'hFFFF_FFFC;
                access(ra, int'($urandom_range(0, 2)));
            end
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
`ifdef ICACHE_STATS_EN
        chk("final_hit_count", 64'(hit_count), 64'(exp_hits));
        chk("final_miss_count", 64'(miss_count), 64'(exp_misses));
`endif
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
